axi_route_ctrl: RTL
===================

Name: axi_route_ctrl

Overview:
- Sequencing controller for the testbench AXI4 address-routing fabric that fans one master out to three slaves: lmem, star and the uart window.
- Decodes AR/AW addresses once per transaction and latches the chosen target until the transaction completes.
- Drives the select and gate controls of the external channel muxes, so R, W and B traffic follows the latched target, not the live address bus.
- Includes per-direction watchdogs that flag a slave that stops responding.

Parameters:
- BOUNDARY1, 32'h8000_0000, first address of the star region; addresses below it go to lmem.
- BOUNDARY2, 32'hF800_0000, first address of the uart region.
- TIMEOUT, 1024, cycles without response before a timeout flag is set; legal range 2..65535.

Ports:
- aclk  in  1  clock
- rst  in  1  synchronous active-high reset
- arvalid  in  1  master AR valid
- arready  in  1  AR ready from the currently selected slave (post-mux)
- araddr  in  32  master AR address
- rvalid  in  1  R valid from the selected slave
- rready  in  1  master R ready
- rlast  in  1  R last from the selected slave
- awvalid  in  1  master AW valid
- awready  in  1  AW ready from the selected slave
- awaddr  in  32  master AW address
- awlen  in  8  master AW burst length (beats-1)
- wvalid  in  1  master W valid
- wready  in  1  W ready from the selected slave
- bvalid  in  1  B valid from the selected slave
- bready  in  1  master B ready
- timeout_clr  in  1  clears both sticky timeout flags
- ar_gate  out  1  allow arvalid/arready through the mux
- ar_sel  out  2  AR/R target: 0 lmem, 1 star, 2 uart
- r_sel  out  2  R-channel mux select (latched)
- aw_gate  out  1  allow awvalid/awready through the mux
- aw_sel  out  2  AW target
- w_gate  out  1  allow wvalid/wready through the mux
- w_sel  out  2  W/B mux select (latched)
- w_last  out  1  high during the final expected W beat
- rd_busy  out  1  read transaction outstanding
- wr_busy  out  1  write transaction outstanding
- rd_timeout  out  1  sticky read watchdog flag
- wr_timeout  out  1  sticky write watchdog flag

Behaviour:
- Address decode:
  - 0 if addr < BOUNDARY1.
  - 1 if BOUNDARY1 <= addr < BOUNDARY2.
  - 2 otherwise.
  - Comparisons are unsigned 32-bit.
  - Encoding 3 is never driven.
- Reset (rst high at a rising edge of aclk):
  - Both FSMs go to IDLE.
  - All latched selects = 0, beat counter = 0, watchdog counters = 0.
  - rd_timeout = wr_timeout = 0.
  - Output values while in IDLE: ar_gate = 1, aw_gate = 1, w_gate = 0, w_last = 0, rd_busy = 0, wr_busy = 0.
  - A reset asserted mid-burst abandons the transaction with no drain.
- Read FSM, states R_IDLE and R_DATA:
  - R_IDLE: ar_gate = 1; ar_sel = decode(araddr), combinational. On arvalid && arready: latch r_sel = decode(araddr) and go to R_DATA.
  - R_DATA: ar_gate = 0, rd_busy = 1, ar_sel holds r_sel. On rvalid && rready && rlast: go to R_IDLE.
  - A new AR is accepted no earlier than the cycle after the last R beat.
- Write FSM, states W_IDLE, W_DATA and W_RESP:
  - W_IDLE: aw_gate = 1; aw_sel = decode(awaddr); w_gate = 0, so W beats arriving before AW are held off. On awvalid && awready: latch w_sel, load beat counter = awlen, go to W_DATA.
  - W_DATA: aw_gate = 0, w_gate = 1, wr_busy = 1; w_last = (counter == 0). On each wvalid && wready: decrement the counter. If the counter was 0 at that handshake, go to W_RESP.
  - W_RESP: w_gate = 0, wr_busy = 1. On bvalid && bready: go to W_IDLE.
  - awlen = 0 gives a single beat. awlen = 255 gives 256 beats; the counter must not wrap before exit.
- The read and write FSMs are fully independent; simultaneous AR and AW handshakes are both accepted in the same cycle.
- Watchdog (one instance per direction):
  - Read counter counts cycles in R_DATA with no rvalid && rready.
  - Write counter counts cycles in W_DATA with no wvalid && wready, and cycles in W_RESP with no bvalid.
  - The counter resets to 0 on any qualifying handshake and on any state change.
  - When the count reaches TIMEOUT-1, the flag is set on the next edge.
  - The counter saturates; the FSM state is unaffected.
  - timeout_clr clears the flags; if the flag's set condition occurs in the same cycle, set wins.
- All outputs other than ar_sel and aw_sel in IDLE are registered or derived from state only; there is no combinational path from the valid/ready inputs to the outputs.

Decomposition:
- Package axi_route_pkg:
  - typedef tgt_e (2-bit: TGT_LMEM = 0, TGT_STAR = 1, TGT_UART = 2).
  - default BOUNDARY constants.
  - function decode_tgt(addr, b1, b2).
  - read and write FSM state enums.
- Sub-module axi_route_wdog:
  - Inputs: TIMEOUT counter, active, progress, clr.
  - Output: sticky flag.
  - Instantiated once for reads and once for writes.

Test Plan:
1. Reset behaviour -> after rst: ar_gate = 1, aw_gate = 1, w_gate = 0, rd_busy = 0, wr_busy = 0, both timeout flags 0.
2. Read route locking:
   - Stimulus: AR to 0x8000_0100 with arlen = 3; during the burst, change araddr to 0x0000_0000.
   - Required: r_sel = 1 for all 4 beats; ar_gate = 0 until the cycle after the rlast handshake.
3. Write 4 beats to 0xF800_0004:
   - Stimulus: wvalid asserted 2 cycles before awvalid.
   - Required: w_gate = 0 until the AW handshake; w_sel = 2; w_last only on beat 4; wr_busy drops the cycle after the B handshake.
4. Concurrent read and write:
   - Stimulus: AR to 0x0000_1000 and AW to 0x8000_0000 in the same cycle.
   - Required: r_sel = 0 and w_sel = 1 simultaneously; both transactions complete independently.
5. Boundaries:
   - Addresses 0x7FFF_FFFF, 0x8000_0000, 0xF7FF_FFFF, 0xF800_0000 decode to 0, 1, 1, 2.
   - awlen = 255 -> exactly 256 W beats accepted.
6. Watchdog:
   - Stimulus: TIMEOUT = 8; AR accepted, then no rvalid.
   - Required: rd_timeout rises after 8 cycles in R_DATA; timeout_clr pulse clears it.
   - Reset during W_DATA: FSM returns to W_IDLE and wr_busy = 0.

Source files
------------

// File: rtl/axi_route_pkg.sv
// Shared types, default region boundaries and the address decode helper for the
// AXI address-routing controller.
package axi_route_pkg;

    typedef enum logic [1:0] {
        TGT_LMEM = 2'd0,
        TGT_STAR = 2'd1,
        TGT_UART = 2'd2
    } tgt_e;

    localparam logic [31:0] DEF_BOUNDARY1 = 32'h8000_0000;
    localparam logic [31:0] DEF_BOUNDARY2 = 32'hF800_0000;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

    // Unsigned compare; encoding 3 is never returned.
    function automatic tgt_e decode_tgt(input logic [31:0] addr,
                                        input logic [31:0] b1,
                                        input logic [31:0] b2);
        if (addr < b1) begin
            return TGT_LMEM;
        end else if (addr < b2) begin
            return TGT_STAR;
        end else begin
            return TGT_UART;
        end
    endfunction

endpackage

// File: rtl/axi_route_wdog.sv
// Per-direction watchdog: counts stalled cycles while active and raises a sticky
// flag once TIMEOUT consecutive cycles pass without progress.
module axi_route_wdog #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic progress,
    input  logic clr,
    output logic flag
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] cnt_q;
    logic        hit;

    assign hit = active && !progress && (cnt_q == LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            flag  <= 1'b0;
        end else begin
            // Saturate at LIMIT so the flag condition stays asserted while stalled.
            if (!active || progress) begin
                cnt_q <= '0;
            end else if (cnt_q != LIMIT) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (hit) begin
                flag <= 1'b1;
            end else if (clr) begin
                flag <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi_route_ctrl.sv
// Routing sequencer for a 1-master / 3-slave AXI4 fabric: decodes AR/AW once per
// transaction, latches the target and gates the external channel muxes.
module axi_route_ctrl
    import axi_route_pkg::*;
#(
    parameter logic [31:0] BOUNDARY1 = DEF_BOUNDARY1,
    parameter logic [31:0] BOUNDARY2 = DEF_BOUNDARY2,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic        aclk,
    input  logic        rst,
    input  logic        arvalid,
    input  logic        arready,
    input  logic [31:0] araddr,
    input  logic        rvalid,
    input  logic        rready,
    input  logic        rlast,
    input  logic        awvalid,
    input  logic        awready,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    input  logic        bready,
    input  logic        timeout_clr,
    output logic        ar_gate,
    output logic [1:0]  ar_sel,
    output logic [1:0]  r_sel,
    output logic        aw_gate,
    output logic [1:0]  aw_sel,
    output logic        w_gate,
    output logic [1:0]  w_sel,
    output logic        w_last,
    output logic        rd_busy,
    output logic        wr_busy,
    output logic        rd_timeout,
    output logic        wr_timeout
);

    rd_state_e   rd_state_q;
    wr_state_e   wr_state_q;
    tgt_e        r_sel_q;
    tgt_e        w_sel_q;
    tgt_e        ar_tgt;
    tgt_e        aw_tgt;
    logic [7:0]  beat_cnt_q;

    assign ar_tgt = decode_tgt(araddr, BOUNDARY1, BOUNDARY2);
    assign aw_tgt = decode_tgt(awaddr, BOUNDARY1, BOUNDARY2);

    always_ff @(posedge aclk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            r_sel_q    <= TGT_LMEM;
        end else begin
            unique case (rd_state_q)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        r_sel_q    <= ar_tgt;
                        rd_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid && rready && rlast) begin
                        rd_state_q <= R_IDLE;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            w_sel_q    <= TGT_LMEM;
            beat_cnt_q <= '0;
        end else begin
            unique case (wr_state_q)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        w_sel_q    <= aw_tgt;
                        beat_cnt_q <= awlen;
                        wr_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    // Counter holds at zero on the final beat so it never wraps.
                    if (wvalid && wready) begin
                        if (beat_cnt_q == 8'd0) begin
                            wr_state_q <= W_RESP;
                        end else begin
                            beat_cnt_q <= beat_cnt_q - 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid && bready) begin
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    assign ar_gate = (rd_state_q == R_IDLE);
    assign ar_sel  = ar_gate ? ar_tgt : r_sel_q;
    assign r_sel   = r_sel_q;
    assign rd_busy = (rd_state_q == R_DATA);

    assign aw_gate = (wr_state_q == W_IDLE);
    assign aw_sel  = aw_gate ? aw_tgt : w_sel_q;
    assign w_gate  = (wr_state_q == W_DATA);
    assign w_sel   = w_sel_q;
    assign w_last  = w_gate && (beat_cnt_q == 8'd0);
    assign wr_busy = (wr_state_q != W_IDLE);

    axi_route_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_rd_wdog (
        .clk      (aclk),
        .rst      (rst),
        .active   (rd_busy),
        .progress (rvalid && rready),
        .clr      (timeout_clr),
        .flag     (rd_timeout)
    );

    // B progress is bvalid alone: a slave offering a response is not stalled.
    axi_route_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wr_wdog (
        .clk      (aclk),
        .rst      (rst),
        .active   (wr_busy),
        .progress ((w_gate && wvalid && wready) || ((wr_state_q == W_RESP) && bvalid)),
        .clr      (timeout_clr),
        .flag     (wr_timeout)
    );

endmodule
